gpio_controller: RTL
====================

// Module: gpio_controller
// PURPOSE
//   Memory-mapped GPIO peripheral for the VESP core, placed behind the data-bus decoder beside RAM.
//   Generalises the fixed 16-pin gpioPorts block:
//   - parametrised pin count
//   - per-pin direction
//   - atomic set/clear of output bits
//   - metastability-safe input synchronisation
//   - per-pin edge-triggered interrupts with write-1-to-clear status
// PARAMETERS
//   WIDTH        16  number of GPIO pins, 1..32
//   SYNC_STAGES  2   input synchroniser depth, >=2
// PORTS
//   clk        in     1      system clock; all state updates on rising edge
//   reset      in     1      synchronous, active-high reset
//   addr       in     3      word offset of register (bus byte address [4:2])
//   we         in     1      write strobe; one write per cycle when high
//   wdata      in     32     write data; bits above WIDTH ignored
//   rdata      out    32     read data, combinational from addr; bits above WIDTH read 0
//   gpioPorts  inout  WIDTH  pads; pin i driven with OUT[i] when DIR[i]=1, else 'z
//   irq        out    1      level interrupt = |(STATUS & IRQ_EN)
// BEHAVIOUR
//   Register map (addr):
//     0 DIR     rw   1 = output
//     1 OUT     rw
//     2 IN      ro   synchronised pad value
//     3 OUT_SET wo   OUT |= wdata; reads 0
//     4 OUT_CLR wo   OUT &= ~wdata; reads 0
//     5 IRQ_EN  rw
//     6 EDGE    rw   1 = rising, 0 = falling
//     7 STATUS  rw1c
//   Writes:
//   - Take effect on the clk edge where we=1.
//   - New value is visible on rdata and gpioPorts the next cycle.
//   - Writes to IN are ignored.
//   Synchroniser:
//   - Each pad passes through SYNC_STAGES flops.
//   - IN reflects a pad change SYNC_STAGES cycles later.
//   - Output pins read back their driven level through the same path.
//   Edge detect:
//   - prev <= IN each cycle.
//   - Rising event = IN & ~prev. Falling event = ~IN & prev.
//   - The selected event sets STATUS[i] regardless of IRQ_EN[i].
//   Arming:
//   - After reset deasserts, an arm counter suppresses all STATUS setting for SYNC_STAGES+1 cycles.
//   - This prevents spurious edges while the synchroniser fills.
//   - Counter width is $clog2(SYNC_STAGES+2). It saturates once armed.
//   STATUS:
//   - Cleared per bit by writing 1 to addr 7.
//   - If an event and a W1C hit the same bit in the same cycle, set wins (bit stays 1).
//   - Bits not written 1 are unaffected.
//   IRQ:
//   - Combinational from registered STATUS/IRQ_EN.
//   - Asserts one cycle after the event is detected.
//   - Stays high until all enabled pending bits are cleared or disabled.
//   Reset values (all state 0):
//   - DIR=0, so all pins are inputs and gpioPorts is all 'z.
//   - OUT=0, IRQ_EN=0, EDGE=0, STATUS=0.
//   - Synchroniser flops=0, prev=0, arm counter=0.
//   - irq=0.
//   - rdata follows addr: 0 for every register except IN, which shows the synchroniser output, all zeros immediately after reset.
//   Reset mid-operation:
//   - Asserting reset in any cycle overrides a concurrent write.
//   - All state returns to reset values on that edge.
//   - Pads float the following cycle.
//   Addr decode:
//   - Full 3-bit decode; no unused codes, no aliasing.
//   - Unwritten bits above WIDTH are never stored.
// TESTING
//   1 Reset, DIR=0x00FF, OUT=0x00A5:
//     -> gpioPorts[7:0]=0xA5, [15:8]='z
//     -> readback DIR=0x00FF, OUT=0x00A5
//   2 OUT=0x00F0, then OUT_SET=0x000F, then OUT_CLR=0x0081:
//     -> OUT reads 0x00FF, then 0x007E
//     -> reads of addr 3/4 return 0
//   3 Bench drives pin 9 low->high:
//     -> IN[9]=1 exactly SYNC_STAGES cycles later
//     -> with EDGE[9]=1, IRQ_EN[9]=1: STATUS=0x0200 and irq=1 next cycle
//     -> W1C 0x0200 -> irq=0
//   4 EDGE[3]=0, pin 3 high->low while writing STATUS=0x0008 in the detect cycle
//     -> STATUS[3] stays 1 (set wins)
//     -> with IRQ_EN=0: irq=0
//   5 Pin 0 held high through reset release
//     -> no STATUS bit set during arm window
//     -> later 1->0->1 toggle with EDGE=1 sets STATUS[0]
//   6 Reset asserted during a write of DIR=0xFFFF
//     -> DIR=0, all pads 'z, irq=0 next cycle

Source files
------------

// File: rtl/gpio_controller.sv
// rtl/gpio_controller.sv - memory-mapped GPIO with per-pin direction, set/clear, synchronised inputs and edge interrupts
module gpio_controller #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       addr,
  input  logic             we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  inout  wire  [WIDTH-1:0] gpioPorts,
  output logic             irq
);

  localparam logic [2:0] A_DIR    = 3'd0;
  localparam logic [2:0] A_OUT    = 3'd1;
  localparam logic [2:0] A_IN     = 3'd2;
  localparam logic [2:0] A_SET    = 3'd3;
  localparam logic [2:0] A_CLR    = 3'd4;
  localparam logic [2:0] A_IRQ_EN = 3'd5;
  localparam logic [2:0] A_EDGE   = 3'd6;
  localparam logic [2:0] A_STATUS = 3'd7;

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] dir_q, out_q, irq_en_q, edge_q, status_q, prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [ARM_W-1:0] arm_cnt;
  logic [WIDTH-1:0] wd, in_w, evt, w1c, status_next, rd;
  logic             armed;
  logic             unused_wdata;

  assign wd           = wdata[WIDTH-1:0];
  assign unused_wdata = ^wdata;
  assign in_w         = sync_q[SYNC_STAGES-1];
  assign armed        = (arm_cnt == ARM_DONE);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign gpioPorts[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  // Event and W1C in the same cycle: the OR after the clear lets set win.
  always_comb begin
    evt         = (edge_q & in_w & ~prev_q) | (~edge_q & ~in_w & prev_q);
    w1c         = (we && addr == A_STATUS) ? wd : '0;
    status_next = (status_q & ~w1c) | (armed ? evt : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q    <= '0;
      out_q    <= '0;
      irq_en_q <= '0;
      edge_q   <= '0;
      status_q <= '0;
      prev_q   <= '0;
      arm_cnt  <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= gpioPorts;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q   <= in_w;
      status_q <= status_next;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
      if (we) begin
        case (addr)
          A_DIR:    dir_q    <= wd;
          A_OUT:    out_q    <= wd;
          A_SET:    out_q    <= out_q | wd;
          A_CLR:    out_q    <= out_q & ~wd;
          A_IRQ_EN: irq_en_q <= wd;
          A_EDGE:   edge_q   <= wd;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      A_DIR:    rd = dir_q;
      A_OUT:    rd = out_q;
      A_IN:     rd = in_w;
      A_IRQ_EN: rd = irq_en_q;
      A_EDGE:   rd = edge_q;
      A_STATUS: rd = status_q;
      default:  rd = '0;
    endcase
  end

  assign rdata = 32'(rd);
  assign irq   = |(status_q & irq_en_q);

endmodule
